// File: rtl/uart_pkg.sv
// Shared definitions for the UART/ALU byte controller: FSM state encoding,
// default widths and the ALU opcode set used by the ALU and the bench.
package uart_pkg;

  localparam int DBIT_DEF  = 8;
  localparam int NB_OP_DEF = 6;

  // Controller states, 3-bit encoding
  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_B  = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] CALC    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;

  // ALU opcodes (MIPS funct-style)
  localparam logic [NB_OP_DEF-1:0] ALU_ADD = 6'h20;
  localparam logic [NB_OP_DEF-1:0] ALU_SUB = 6'h22;
  localparam logic [NB_OP_DEF-1:0] ALU_AND = 6'h24;
  localparam logic [NB_OP_DEF-1:0] ALU_OR  = 6'h25;
  localparam logic [NB_OP_DEF-1:0] ALU_XOR = 6'h26;
  localparam logic [NB_OP_DEF-1:0] ALU_NOR = 6'h27;
  localparam logic [NB_OP_DEF-1:0] ALU_SRA = 6'h03;
  localparam logic [NB_OP_DEF-1:0] ALU_SRL = 6'h02;

endpackage

// File: rtl/uart_alu_if_if.sv
// Bus bundle between the controller and its UART rx/tx and ALU neighbours.
// master: the controller side; slave: the environment (UART + ALU).
interface uart_alu_if_if #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
);
  logic             i_rx_done;
  logic [DBIT-1:0]  i_rx_data;
  logic [DBIT-1:0]  i_alu_result;
  logic             i_tx_done;
  logic [DBIT-1:0]  o_alu_a;
  logic [DBIT-1:0]  o_alu_b;
  logic [NB_OP-1:0] o_alu_op;
  logic             o_tx_start;
  logic [DBIT-1:0]  o_tx_data;
  logic             o_drop;
  logic             o_timeout;

  modport master (
    input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data, o_drop, o_timeout
  );

  modport slave (
    output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data, o_drop, o_timeout
  );
endinterface

// File: rtl/uart_if_timer.sv
// Inter-byte timeout counter. Counts while enabled, clears on request,
// and flags expiry in the cycle the count sits at TIMEOUT_CYC-1.
module uart_if_timer #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  assign expire = enable && (cnt == CW'(TIMEOUT_CYC - 1));

  // count up while enabled; wrap to 0 on expiry so a stale count never lingers
  always_ff @(posedge i_clk) begin
    if (i_rst || clear)  cnt <= '0;
    else if (enable)     cnt <= expire ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/uart_alu_if.sv
// Byte controller between UART rx and tx: gathers A, B, opcode, presents them
// to the combinational ALU, captures the result and issues a one-cycle
// transmit start, then waits for tx completion.
// Optional inter-byte timeout: define UART_IF_TIMEOUT_EN.
module uart_alu_if
  import uart_pkg::*;
#(
  parameter int          DBIT        = DBIT_DEF,
  parameter int          NB_OP       = NB_OP_DEF,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  uart_alu_if_if.master        bus
);
  logic [2:0]       state;
  logic [DBIT-1:0]  a_reg, b_reg, result_reg;
  logic [NB_OP-1:0] op_reg;
  logic             drop_q, timeout_q;
  logic             tmo_fire;

`ifdef UART_IF_TIMEOUT_EN
  logic tmr_en, tmr_expire;

  // timer runs only while a partial set is pending; any accepted byte restarts it
  assign tmr_en   = (state == WAIT_B) || (state == WAIT_OP);
  assign tmo_fire = tmr_expire && !bus.i_rx_done;

  uart_if_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  (bus.i_rx_done || !tmr_en),
    .enable (tmr_en),
    .expire (tmr_expire)
  );
`else
  assign tmo_fire = 1'b0;
`endif

  // sequencing FSM plus the registered drop/timeout pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= WAIT_A;
      drop_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      drop_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        WAIT_A:  if (bus.i_rx_done) state <= WAIT_B;
        WAIT_B:  begin
          if (bus.i_rx_done)  state <= WAIT_OP;
          else if (tmo_fire) begin
            state     <= WAIT_A;
            timeout_q <= 1'b1;
          end
        end
        WAIT_OP: begin
          if (bus.i_rx_done)  state <= CALC;
          else if (tmo_fire) begin
            state     <= WAIT_A;
            timeout_q <= 1'b1;
          end
        end
        CALC:    begin
          state  <= SEND;
          drop_q <= bus.i_rx_done;
        end
        SEND:    begin
          state  <= WAIT_TX;
          drop_q <= bus.i_rx_done;
        end
        WAIT_TX: begin
          if (bus.i_tx_done) state <= WAIT_A;
          drop_q <= bus.i_rx_done;
        end
        default: state <= WAIT_A;
      endcase
    end
  end

  // operand/result capture; registers hold until their next load
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
    end else begin
      if (state == WAIT_A  && bus.i_rx_done) a_reg  <= bus.i_rx_data;
      if (state == WAIT_B  && bus.i_rx_done) b_reg  <= bus.i_rx_data;
      if (state == WAIT_OP && bus.i_rx_done) op_reg <= bus.i_rx_data[NB_OP-1:0];
      if (state == CALC)                     result_reg <= bus.i_alu_result;
    end
  end

  assign bus.o_alu_a    = a_reg;
  assign bus.o_alu_b    = b_reg;
  assign bus.o_alu_op   = op_reg;
  assign bus.o_tx_data  = result_reg;
  assign bus.o_tx_start = (state == SEND);
  assign bus.o_drop     = drop_q;
  assign bus.o_timeout  = timeout_q;
endmodule
